auth_keypad_ctrl: RTL and testbench
===================================

// Module: auth_keypad_ctrl
// PURPOSE
//  Parametrised multi-digit authorization controller for the home top-level.
//  It collects a keypad digit sequence and compares it against a stored code.
//  Repeated failures trigger a timed lockout, and an idle entry is abandoned after a timeout.
//  While access is granted, the stored code can be reprogrammed.
// PARAMETERS
//  DIGIT_W        4        width of one keypad digit
//  CODE_LEN       4        digits per code (>=1)
//  DEFAULT_CODE   16'h1234 code loaded at reset; width DIGIT_W*CODE_LEN, first digit in MSBs
//  MAX_FAILS      3        consecutive failures before lockout (>=1)
//  LOCKOUT_CYCLES 100      lockout duration in clk cycles (>=1)
//  ENTRY_TIMEOUT  50       idle cycles in ENTRY before entry is discarded (>=1)
// PORTS
//  clk          in  1                clock, rising edge
//  reset        in  1                asynchronous, active-low reset (0 = reset)
//  digit        in  DIGIT_W          keypad digit, sampled when digit_valid=1
//  digit_valid  in  1                one-cycle strobe per key press
//  validate     in  1                one-cycle strobe: check entry (or program it if prog_en=1)
//  clear        in  1                one-cycle strobe: discard entry / log out
//  prog_en      in  1                qualifies validate as "store new code" (GRANTED only)
//  auth_status  out 1                1 while in GRANTED
//  auth_fail    out 1                one-cycle pulse on each rejected validate
//  code_updated out 1                one-cycle pulse when a new code is stored
//  locked       out 1                1 while in LOCKED
//  fail_count   out $clog2(MAX_FAILS+1)  consecutive failures so far
// BEHAVIOUR
//  States:
//  - IDLE, ENTRY, GRANTED and LOCKED; all outputs are registered.
//  Reset:
//  - State goes to IDLE; stored code = DEFAULT_CODE; buffer, entry count and overflow flag are cleared.
//  - All outputs go to 0, regardless of any operation in progress.
//  Entry buffer:
//  - Shift register of CODE_LEN digits; each new digit enters the LSBs.
//  - Digit count saturates at CODE_LEN.
//  - A digit arriving when the count is already CODE_LEN sets the overflow flag.
//  IDLE:
//  - digit_valid: load the digit, count=1, go to ENTRY.
//  - validate with an empty entry counts as a failure.
//  ENTRY:
//  - digit_valid: shift the digit in and reset the timeout counter.
//  - Timeout: after ENTRY_TIMEOUT consecutive cycles with no strobe, discard the entry and return to IDLE.
//    A timeout is not counted as a failure.
//  - clear: discard the entry and go to IDLE.
//  Validate check:
//  - Match means count==CODE_LEN AND no overflow AND buffer==stored code.
//  - The result is visible the cycle after the validate edge.
//  - Match: go to GRANTED, fail_count=0.
//  - Mismatch: auth_fail pulse, fail_count+1, buffer cleared.
//    If the new fail_count equals MAX_FAILS, go to LOCKED; otherwise go to IDLE.
//  GRANTED:
//  - digit_valid fills the buffer without leaving GRANTED.
//  - validate with prog_en=1 and an exact CODE_LEN entry (no overflow): store the buffer as the new code.
//    This pulses code_updated, clears the buffer, and stays in GRANTED.
//  - Any other validate in GRANTED only clears the buffer. It is not a failure.
//  - clear: log out to IDLE and clear the buffer.
//  - No timeout applies in GRANTED.
//  LOCKED:
//  - Every input except reset is ignored.
//  - The counter loads LOCKOUT_CYCLES-1 on entry and decrements each cycle.
//  - At 0, go to IDLE and clear fail_count. locked is high for exactly LOCKOUT_CYCLES cycles.
//  Priority in one cycle: clear > validate > digit_valid.
//  - The lower-priority strobes are dropped, and the timeout counter resets.
//  prog_en is ignored outside GRANTED; validate+prog_en in ENTRY is a normal check.
// TESTING
//  - Defaults. Digits 1,2,3,4 then validate -> auth_status=1 the next cycle; fail_count=0.
//  - Digits 1,2,3,5 then validate -> auth_fail pulse, fail_count=1, state IDLE, auth_status=0.
//  - Three bad codes -> locked=1 for exactly 100 cycles, inputs ignored during lockout.
//    The correct code during lockout is rejected. Afterwards fail_count=0, and 1,2,3,4 is granted.
//  - Digits 1,2,3,4,4 then validate (overflow) -> failure.
//    Digits 1,2 then 50 idle cycles -> IDLE, fail_count unchanged.
//  - In GRANTED, enter 9,8,7,6 then validate with prog_en=1 -> code_updated pulse.
//    Then clear; 1,2,3,4 fails and 9,8,7,6 is granted.
//  - Same-cycle clear+validate in ENTRY -> IDLE with no fail.
//    reset asserted mid-LOCKED -> IDLE, locked=0, stored code = 16'h1234.

Source files
------------

// File: rtl/auth_keypad_ctrl_if.sv
// Keypad authorization bus: key strobes in, status/pulse outputs back.
interface auth_keypad_ctrl_if #(
  parameter int unsigned DIGIT_W = 4,
  parameter int unsigned FAIL_W  = 2
);
  logic [DIGIT_W-1:0] digit;
  logic               digit_valid;
  logic               validate;
  logic               clear;
  logic               prog_en;
  logic               auth_status;
  logic               auth_fail;
  logic               code_updated;
  logic               locked;
  logic [FAIL_W-1:0]  fail_count;

  // Keypad / host side
  modport master (
    output digit, digit_valid, validate, clear, prog_en,
    input  auth_status, auth_fail, code_updated, locked, fail_count
  );

  // Controller side
  modport slave (
    input  digit, digit_valid, validate, clear, prog_en,
    output auth_status, auth_fail, code_updated, locked, fail_count
  );
endinterface

// File: rtl/auth_keypad_ctrl.sv
// Multi-digit keypad authorization controller with failure lockout,
// idle-entry timeout and in-session code reprogramming.
module auth_keypad_ctrl #(
  parameter int unsigned                    DIGIT_W        = 4,
  parameter int unsigned                    CODE_LEN       = 4,
  parameter logic [DIGIT_W*CODE_LEN-1:0]    DEFAULT_CODE   = 16'h1234,
  parameter int unsigned                    MAX_FAILS      = 3,
  parameter int unsigned                    LOCKOUT_CYCLES = 100,
  parameter int unsigned                    ENTRY_TIMEOUT  = 50
) (
  input  logic               clk,
  input  logic               reset,
  auth_keypad_ctrl_if.slave  bus
);

  localparam int unsigned BUF_W  = DIGIT_W * CODE_LEN;
  localparam int unsigned CNT_W  = $clog2(CODE_LEN + 1);
  localparam int unsigned FAIL_W = $clog2(MAX_FAILS + 1);
  localparam int unsigned LOCK_W = $clog2(LOCKOUT_CYCLES + 1);
  localparam int unsigned TMO_W  = $clog2(ENTRY_TIMEOUT + 1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ENTRY   = 2'd1,
    ST_GRANTED = 2'd2,
    ST_LOCKED  = 2'd3
  } state_e;

  state_e              state_q, state_d;
  logic [BUF_W-1:0]    code_q, code_d;
  logic [BUF_W-1:0]    buf_q, buf_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                ovf_q, ovf_d;
  logic [FAIL_W-1:0]   fail_q, fail_d;
  logic [TMO_W-1:0]    tmo_q, tmo_d;
  logic [LOCK_W-1:0]   lock_q, lock_d;
  logic                auth_status_q, auth_status_d;
  logic                auth_fail_q, auth_fail_d;
  logic                code_updated_q, code_updated_d;
  logic                locked_q, locked_d;

  logic                entry_full;
  logic                entry_exact;
  logic                match;
  logic [FAIL_W-1:0]   fail_inc;
  logic                reject;
  logic                clr_buf;
  logic                shift_in;

  assign entry_full  = (cnt_q == CNT_W'(CODE_LEN));
  assign entry_exact = entry_full && !ovf_q;
  assign match       = entry_exact && (buf_q == code_q);
  assign fail_inc    = fail_q + FAIL_W'(1);

  // State register and datapath flops
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q        <= ST_IDLE;
      code_q         <= DEFAULT_CODE;
      buf_q          <= '0;
      cnt_q          <= '0;
      ovf_q          <= 1'b0;
      fail_q         <= '0;
      tmo_q          <= '0;
      lock_q         <= '0;
      auth_status_q  <= 1'b0;
      auth_fail_q    <= 1'b0;
      code_updated_q <= 1'b0;
      locked_q       <= 1'b0;
    end else begin
      state_q        <= state_d;
      code_q         <= code_d;
      buf_q          <= buf_d;
      cnt_q          <= cnt_d;
      ovf_q          <= ovf_d;
      fail_q         <= fail_d;
      tmo_q          <= tmo_d;
      lock_q         <= lock_d;
      auth_status_q  <= auth_status_d;
      auth_fail_q    <= auth_fail_d;
      code_updated_q <= code_updated_d;
      locked_q       <= locked_d;
    end
  end

  // Next-state, entry buffer, counters and output pulses
  always_comb begin
    state_d        = state_q;
    code_d         = code_q;
    buf_d          = buf_q;
    cnt_d          = cnt_q;
    ovf_d          = ovf_q;
    fail_d         = fail_q;
    tmo_d          = tmo_q;
    lock_d         = lock_q;
    auth_fail_d    = 1'b0;
    code_updated_d = 1'b0;
    reject         = 1'b0;
    clr_buf        = 1'b0;
    shift_in       = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        tmo_d = '0;
        if (bus.clear) begin
          clr_buf = 1'b1;
        end else if (bus.validate) begin
          // An empty entry can never match
          clr_buf = 1'b1;
          reject  = 1'b1;
        end else if (bus.digit_valid) begin
          buf_d   = BUF_W'(bus.digit);
          cnt_d   = CNT_W'(1);
          ovf_d   = 1'b0;
          state_d = ST_ENTRY;
        end
      end

      ST_ENTRY: begin
        if (bus.clear) begin
          clr_buf = 1'b1;
          tmo_d   = '0;
          state_d = ST_IDLE;
        end else if (bus.validate) begin
          clr_buf = 1'b1;
          tmo_d   = '0;
          if (match) begin
            fail_d  = '0;
            state_d = ST_GRANTED;
          end else begin
            reject = 1'b1;
          end
        end else if (bus.digit_valid) begin
          shift_in = 1'b1;
          tmo_d    = '0;
        end else if (tmo_q == TMO_W'(ENTRY_TIMEOUT - 1)) begin
          // Abandoned entry: discard silently, no failure recorded
          clr_buf = 1'b1;
          tmo_d   = '0;
          state_d = ST_IDLE;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end

      ST_GRANTED: begin
        tmo_d = '0;
        if (bus.clear) begin
          clr_buf = 1'b1;
          state_d = ST_IDLE;
        end else if (bus.validate) begin
          clr_buf = 1'b1;
          if (bus.prog_en && entry_exact) begin
            code_d         = buf_q;
            code_updated_d = 1'b1;
          end
        end else if (bus.digit_valid) begin
          shift_in = 1'b1;
        end
      end

      ST_LOCKED: begin
        tmo_d = '0;
        if (lock_q == '0) begin
          fail_d  = '0;
          state_d = ST_IDLE;
        end else begin
          lock_d = lock_q - LOCK_W'(1);
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Shift a digit into the LSBs; a digit beyond a full entry flags overflow
    if (shift_in) begin
      buf_d = (buf_q << DIGIT_W) | BUF_W'(bus.digit);
      if (entry_full) begin
        ovf_d = 1'b1;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end

    // Rejected validate: count it and lock out once the limit is reached
    if (reject) begin
      auth_fail_d = 1'b1;
      fail_d      = fail_inc;
      if (fail_inc == FAIL_W'(MAX_FAILS)) begin
        lock_d  = LOCK_W'(LOCKOUT_CYCLES - 1);
        state_d = ST_LOCKED;
      end else begin
        state_d = ST_IDLE;
      end
    end

    if (clr_buf) begin
      buf_d = '0;
      cnt_d = '0;
      ovf_d = 1'b0;
    end

    auth_status_d = (state_d == ST_GRANTED);
    locked_d      = (state_d == ST_LOCKED);
  end

  assign bus.auth_status  = auth_status_q;
  assign bus.auth_fail    = auth_fail_q;
  assign bus.code_updated = code_updated_q;
  assign bus.locked       = locked_q;
  assign bus.fail_count   = fail_q;

endmodule

// File: tb/tb_auth_keypad_ctrl.sv
// Directed self-checking bench for auth_keypad_ctrl.
`timescale 1ns/1ps
module tb_auth_keypad_ctrl;

  logic        clk;
  logic        reset;
  int unsigned cyc;
  int          n_checks;
  int          n_errors;
  int unsigned t0;

  auth_keypad_ctrl_if #(.DIGIT_W(4), .FAIL_W(2)) bus ();

  auth_keypad_ctrl #(
    .DIGIT_W       (4),
    .CODE_LEN      (4),
    .DEFAULT_CODE  (16'h1234),
    .MAX_FAILS     (3),
    .LOCKOUT_CYCLES(100),
    .ENTRY_TIMEOUT (50)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic press(input logic [3:0] d);
    bus.digit       = d;
    bus.digit_valid = 1'b1;
    tick();
    bus.digit_valid = 1'b0;
  endtask

  task automatic enter4(input logic [15:0] code);
    press(code[15:12]);
    press(code[11:8]);
    press(code[7:4]);
    press(code[3:0]);
  endtask

  task automatic do_validate(input logic prog);
    bus.validate = 1'b1;
    bus.prog_en  = prog;
    tick();
    bus.validate = 1'b0;
    bus.prog_en  = 1'b0;
  endtask

  task automatic do_clear();
    bus.clear = 1'b1;
    tick();
    bus.clear = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    reset            = 1'b0;
    bus.digit        = '0;
    bus.digit_valid  = 1'b0;
    bus.validate     = 1'b0;
    bus.clear        = 1'b0;
    bus.prog_en      = 1'b0;

    // Reset values
    idle(3);
    check("rst_auth_status", 32'(bus.auth_status), 0);
    check("rst_auth_fail", 32'(bus.auth_fail), 0);
    check("rst_code_updated", 32'(bus.code_updated), 0);
    check("rst_locked", 32'(bus.locked), 0);
    check("rst_fail_count", 32'(bus.fail_count), 0);
    reset = 1'b1;
    tick();

    // Default code grants
    enter4(16'h1234);
    do_validate(1'b0);
    check("grant_status", 32'(bus.auth_status), 1);
    check("grant_fail_count", 32'(bus.fail_count), 0);
    check("grant_no_fail", 32'(bus.auth_fail), 0);
    do_clear();
    check("logout_status", 32'(bus.auth_status), 0);

    // Wrong code rejected, pulse lasts one cycle
    enter4(16'h1235);
    do_validate(1'b0);
    check("bad_fail_pulse", 32'(bus.auth_fail), 1);
    check("bad_fail_count", 32'(bus.fail_count), 1);
    check("bad_status", 32'(bus.auth_status), 0);
    tick();
    check("bad_pulse_end", 32'(bus.auth_fail), 0);

    // Success clears the failure count
    enter4(16'h1234);
    do_validate(1'b0);
    check("regrant_status", 32'(bus.auth_status), 1);
    check("regrant_fail_count", 32'(bus.fail_count), 0);
    do_clear();

    // Three bad codes -> lockout
    enter4(16'h1235);
    do_validate(1'b0);
    enter4(16'h0000);
    do_validate(1'b0);
    check("fail2_count", 32'(bus.fail_count), 2);
    check("fail2_not_locked", 32'(bus.locked), 0);
    enter4(16'h4321);
    do_validate(1'b0);
    t0 = cyc;
    check("lock_locked", 32'(bus.locked), 1);
    check("lock_fail_pulse", 32'(bus.auth_fail), 1);
    check("lock_fail_count", 32'(bus.fail_count), 3);

    // Correct code during lockout is ignored
    enter4(16'h1234);
    do_validate(1'b0);
    check("lock_ign_status", 32'(bus.auth_status), 0);
    check("lock_ign_fail", 32'(bus.auth_fail), 0);
    check("lock_ign_locked", 32'(bus.locked), 1);
    check("lock_ign_count", 32'(bus.fail_count), 3);
    do_clear();
    check("lock_clear_ign", 32'(bus.locked), 1);
    for (int i = 0; i < 300 && bus.locked; i++) tick();
    check("lock_released", 32'(bus.locked), 0);
    check("lock_duration", cyc - t0, 100);
    check("lock_fail_reset", 32'(bus.fail_count), 0);
    enter4(16'h1234);
    do_validate(1'b0);
    check("post_lock_grant", 32'(bus.auth_status), 1);
    do_clear();

    // 49 idle cycles keep the partial entry
    press(4'h1);
    press(4'h2);
    idle(49);
    press(4'h3);
    press(4'h4);
    do_validate(1'b0);
    check("tmo49_grant", 32'(bus.auth_status), 1);
    do_clear();

    // Overflow (five digits) is a failure
    enter4(16'h1234);
    press(4'h4);
    do_validate(1'b0);
    check("ovf_fail_pulse", 32'(bus.auth_fail), 1);
    check("ovf_fail_count", 32'(bus.fail_count), 1);
    check("ovf_status", 32'(bus.auth_status), 0);

    // 50 idle cycles discard the entry without counting a failure
    press(4'h1);
    press(4'h2);
    idle(50);
    check("tmo50_fail_count", 32'(bus.fail_count), 1);
    check("tmo50_no_fail", 32'(bus.auth_fail), 0);
    enter4(16'h1234);
    do_validate(1'b0);
    check("tmo50_grant", 32'(bus.auth_status), 1);
    check("tmo50_count_clr", 32'(bus.fail_count), 0);

    // GRANTED: plain validate and short program attempt do nothing
    enter4(16'h5555);
    do_validate(1'b0);
    check("gr_val_status", 32'(bus.auth_status), 1);
    check("gr_val_no_fail", 32'(bus.auth_fail), 0);
    check("gr_val_no_upd", 32'(bus.code_updated), 0);
    press(4'h9);
    press(4'h8);
    do_validate(1'b1);
    check("gr_short_no_upd", 32'(bus.code_updated), 0);

    // Reprogram to 9876
    enter4(16'h9876);
    do_validate(1'b1);
    check("prog_updated", 32'(bus.code_updated), 1);
    check("prog_status", 32'(bus.auth_status), 1);
    tick();
    check("prog_pulse_end", 32'(bus.code_updated), 0);
    do_clear();
    enter4(16'h1234);
    do_validate(1'b0);
    check("old_code_fail", 32'(bus.auth_fail), 1);
    check("old_code_status", 32'(bus.auth_status), 0);
    enter4(16'h9876);
    do_validate(1'b0);
    check("new_code_grant", 32'(bus.auth_status), 1);
    do_clear();

    // Same-cycle clear+validate in ENTRY: clear wins, no failure
    enter4(16'h9876);
    bus.clear    = 1'b1;
    bus.validate = 1'b1;
    tick();
    bus.clear    = 1'b0;
    bus.validate = 1'b0;
    check("clrval_no_fail", 32'(bus.auth_fail), 0);
    check("clrval_status", 32'(bus.auth_status), 0);
    check("clrval_count", 32'(bus.fail_count), 0);

    // Validate with an empty entry in IDLE fails
    do_validate(1'b0);
    check("empty_fail", 32'(bus.auth_fail), 1);
    check("empty_count", 32'(bus.fail_count), 1);

    // Reset in the middle of a lockout
    do_validate(1'b0);
    do_validate(1'b0);
    check("lock2_locked", 32'(bus.locked), 1);
    idle(10);
    reset = 1'b0;
    #2;
    check("midrst_locked", 32'(bus.locked), 0);
    check("midrst_count", 32'(bus.fail_count), 0);
    check("midrst_status", 32'(bus.auth_status), 0);
    tick();
    reset = 1'b1;
    tick();
    enter4(16'h1234);
    do_validate(1'b0);
    check("midrst_default_code", 32'(bus.auth_status), 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
